// File: rtl/sprite_pixel_fetch.sv
// Sprite fetch and layering stage: drives both sprite ROMs and resolves a palette index per pixel.
// It also accumulates player/enemy overlap and reports it once per frame.
module sprite_pixel_fetch #(
    parameter int                ADDR_W      = 13,
    parameter int                DATA_W      = 4,
    parameter logic [DATA_W-1:0] TRANSPARENT = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic              pix_valid,
    input  logic [8:0]        PixelX,
    input  logic [8:0]        PixelY,
    input  logic              player_is_obj,
    input  logic [ADDR_W-1:0] player_address,
    input  logic              enemy_is_obj,
    input  logic [ADDR_W-1:0] enemy_address,
    output logic [ADDR_W-1:0] player_rom_addr,
    input  logic [DATA_W-1:0] player_rom_data,
    output logic [ADDR_W-1:0] enemy_rom_addr,
    input  logic [DATA_W-1:0] enemy_rom_data,
    output logic              out_valid,
    output logic [8:0]        out_X,
    output logic [8:0]        out_Y,
    output logic [DATA_W-1:0] palette_idx,
    output logic [1:0]        out_src,
    output logic              collision,
    output logic [7:0]        collision_count
);

    localparam logic [1:0] SRC_BG     = 2'b00;
    localparam logic [1:0] SRC_PLAYER = 2'b01;
    localparam logic [1:0] SRC_ENEMY  = 2'b10;

    logic       s1_valid, s2_valid;
    logic [8:0] s1_x, s1_y, s2_x, s2_y;
    logic       s1_p_obj, s1_e_obj, s2_p_obj, s2_e_obj;

    logic       frame_sync1, frame_sync2, frame_dly;
    logic       frame_rise;
    logic       hit_acc;

    logic       p_op, e_op, hit_now;

    // Stage 1: present addresses to the ROMs; a box miss reads address 0.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            player_rom_addr <= '0;
            enemy_rom_addr  <= '0;
            s1_valid        <= 1'b0;
            s1_x            <= '0;
            s1_y            <= '0;
            s1_p_obj        <= 1'b0;
            s1_e_obj        <= 1'b0;
        end else begin
            s1_valid <= pix_valid;
            if (pix_valid) begin
                player_rom_addr <= player_is_obj ? player_address : '0;
                enemy_rom_addr  <= enemy_is_obj  ? enemy_address  : '0;
                s1_x            <= PixelX;
                s1_y            <= PixelY;
                s1_p_obj        <= player_is_obj;
                s1_e_obj        <= enemy_is_obj;
            end
        end
    end

    // Stage 2: metadata waits one cycle while the ROMs register their data.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s2_valid <= 1'b0;
            s2_x     <= '0;
            s2_y     <= '0;
            s2_p_obj <= 1'b0;
            s2_e_obj <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_x     <= s1_x;
            s2_y     <= s1_y;
            s2_p_obj <= s1_p_obj;
            s2_e_obj <= s1_e_obj;
        end
    end

    always_comb begin
        p_op    = s2_p_obj && (player_rom_data != TRANSPARENT);
        e_op    = s2_e_obj && (enemy_rom_data != TRANSPARENT);
        hit_now = s2_valid && p_op && e_op;
    end

    // Stage 3: player wins over enemy; fully transparent pixels fall to background.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid   <= 1'b0;
            out_X       <= '0;
            out_Y       <= '0;
            palette_idx <= '0;
            out_src     <= SRC_BG;
        end else begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_X <= s2_x;
                out_Y <= s2_y;
                if (p_op) begin
                    palette_idx <= player_rom_data;
                    out_src     <= SRC_PLAYER;
                end else if (e_op) begin
                    palette_idx <= enemy_rom_data;
                    out_src     <= SRC_ENEMY;
                end else begin
                    palette_idx <= TRANSPARENT;
                    out_src     <= SRC_BG;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_sync1 <= 1'b0;
            frame_sync2 <= 1'b0;
            frame_dly   <= 1'b0;
        end else begin
            frame_sync1 <= frame_clk;
            frame_sync2 <= frame_sync1;
            frame_dly   <= frame_sync2;
        end
    end

    assign frame_rise = frame_sync2 && !frame_dly;

    // An overlap landing on the frame edge belongs to the frame that is starting.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hit_acc         <= 1'b0;
            collision       <= 1'b0;
            collision_count <= '0;
        end else if (frame_rise) begin
            collision <= hit_acc;
            if (hit_acc && (collision_count != 8'hFF))
                collision_count <= collision_count + 8'd1;
            hit_acc <= hit_now;
        end else if (hit_now) begin
            hit_acc <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Directed bench for sprite_pixel_fetch: ROM model returns addr[3:0], a scoreboard checks
// every emitted pixel against hand-computed values and its exact output cycle.
module tb_sprite_pixel_fetch;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 4;
    localparam int EXP_W  = 32 + 9 + 9 + DATA_W + 2;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              frame_clk = 1'b0;
    logic              pix_valid = 1'b0;
    logic [8:0]        PixelX = '0;
    logic [8:0]        PixelY = '0;
    logic              player_is_obj = 1'b0;
    logic [ADDR_W-1:0] player_address = '0;
    logic              enemy_is_obj = 1'b0;
    logic [ADDR_W-1:0] enemy_address = '0;
    logic [ADDR_W-1:0] player_rom_addr;
    logic [DATA_W-1:0] player_rom_data = '0;
    logic [ADDR_W-1:0] enemy_rom_addr;
    logic [DATA_W-1:0] enemy_rom_data = '0;
    logic              out_valid;
    logic [8:0]        out_X;
    logic [8:0]        out_Y;
    logic [DATA_W-1:0] palette_idx;
    logic [1:0]        out_src;
    logic              collision;
    logic [7:0]        collision_count;

    logic [EXP_W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    sprite_pixel_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .pix_valid(pix_valid),
        .PixelX(PixelX), .PixelY(PixelY),
        .player_is_obj(player_is_obj), .player_address(player_address),
        .enemy_is_obj(enemy_is_obj), .enemy_address(enemy_address),
        .player_rom_addr(player_rom_addr), .player_rom_data(player_rom_data),
        .enemy_rom_addr(enemy_rom_addr), .enemy_rom_data(enemy_rom_data),
        .out_valid(out_valid), .out_X(out_X), .out_Y(out_Y),
        .palette_idx(palette_idx), .out_src(out_src),
        .collision(collision), .collision_count(collision_count)
    );

    // Clock / reset-independent cycle counter
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Synchronous ROM models with a one-cycle registered read
    always @(posedge Clk) begin
        player_rom_data <= player_rom_addr[3:0];
        enemy_rom_data  <= enemy_rom_addr[3:0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver: one pixel per call, expected result pushed with its due cycle
    task automatic drive_pix(input logic [8:0] x, input logic [8:0] y,
                             input logic p_obj, input logic [ADDR_W-1:0] p_addr,
                             input logic e_obj, input logic [ADDR_W-1:0] e_addr,
                             input logic [DATA_W-1:0] exp_idx, input logic [1:0] exp_src);
        @(negedge Clk);
        pix_valid      = 1'b1;
        PixelX         = x;
        PixelY         = y;
        player_is_obj  = p_obj;
        player_address = p_addr;
        enemy_is_obj   = e_obj;
        enemy_address  = e_addr;
        exp_q.push_back({32'(cyc + 3), x, y, exp_idx, exp_src});
    endtask

    // Idle cycles carry junk on the object inputs; they must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            pix_valid      = 1'b0;
            player_is_obj  = 1'b0;
            player_address = 13'h1FFF;
            enemy_is_obj   = 1'b1;
            enemy_address  = 13'h1EEE;
        end
    endtask

    task automatic pulse_frame();
        idle(1);
        frame_clk = 1'b1;
        idle(4);
        frame_clk = 1'b0;
        idle(4);
    endtask

    // Monitor: pops and compares whenever the DUT presents a pixel
    always @(negedge Clk) begin
        if (!Reset && out_valid) begin
            logic [EXP_W-1:0] e;
            logic [EXP_W-1:0] got;
            n_cmp++;
            got = {32'(cyc), out_X, out_Y, palette_idx, out_src};
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pixel: got %h with nothing expected (cycle|x|y|idx|src)", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL pixel: got %h expected %h (cycle|x|y|idx|src)", got, e);
                end
            end
        end
    end

    initial begin
        // Reset state
        idle(3);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_palette_idx", 32'(palette_idx), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_collision", 32'(collision), 32'd0);
        check("rst_count", 32'(collision_count), 32'd0);
        check("rst_player_addr", 32'(player_rom_addr), 32'd0);
        check("rst_enemy_addr", 32'(enemy_rom_addr), 32'd0);
        Reset = 1'b0;
        idle(2);

        // Reset mid-stream: three pixels in flight, the first already on the output
        drive_pix(9'd1, 9'd2, 1'b1, 13'h0A3, 1'b0, 13'h0, 4'd3, 2'b01);
        drive_pix(9'd2, 9'd2, 1'b1, 13'h0A4, 1'b0, 13'h0, 4'd4, 2'b01);
        drive_pix(9'd3, 9'd2, 1'b1, 13'h0A5, 1'b0, 13'h0, 4'd5, 2'b01);
        idle(1);
        #2 Reset = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_count", 32'(collision_count), 32'd0);
        exp_q.delete();
        idle(2);
        Reset = 1'b0;
        idle(8);

        // Latency and throughput: five back-to-back player pixels
        for (int i = 0; i < 5; i++)
            drive_pix(9'(10 + i), 9'd20, 1'b1, 13'(13'h0A1 + i), 1'b0, 13'h0, 4'(1 + i), 2'b01);
        idle(6);
        check("addr_hold_when_idle", 32'(player_rom_addr), 32'h0A5);

        // Background: both boxes missed, ROM addresses forced to zero
        drive_pix(9'd30, 9'd31, 1'b0, 13'h1234, 1'b0, 13'h0567, 4'd0, 2'b00);
        idle(1);
        check("bg_player_addr", 32'(player_rom_addr), 32'd0);
        check("bg_enemy_addr", 32'(enemy_rom_addr), 32'd0);
        // Both in box but both transparent, then enemy only with player box missed
        drive_pix(9'd32, 9'd31, 1'b1, 13'h0010, 1'b1, 13'h0020, 4'd0, 2'b00);
        drive_pix(9'd33, 9'd31, 1'b0, 13'h0009, 1'b1, 13'h0003, 4'd3, 2'b10);
        idle(4);
        pulse_frame();
        check("transparent_no_collision", 32'(collision), 32'd0);
        check("transparent_no_count", 32'(collision_count), 32'd0);

        // Layering: player on top, then transparent player reveals enemy
        drive_pix(9'd40, 9'd41, 1'b1, 13'h00A7, 1'b1, 13'h01B5, 4'd7, 2'b01);
        drive_pix(9'd40, 9'd42, 1'b1, 13'h00A0, 1'b1, 13'h01B5, 4'd5, 2'b10);
        idle(4);
        pulse_frame();
        check("frame1_collision", 32'(collision), 32'd1);
        check("frame1_count", 32'(collision_count), 32'd1);
        pulse_frame();
        check("frame2_collision", 32'(collision), 32'd0);
        check("frame2_count", 32'(collision_count), 32'd1);

        // Overlap pixel resolved on the same cycle as the frame edge
        drive_pix(9'd50, 9'd51, 1'b1, 13'h00A7, 1'b1, 13'h01B5, 4'd7, 2'b01);
        frame_clk = 1'b1;
        idle(4);
        frame_clk = 1'b0;
        idle(4);
        check("edge_overlap_collision", 32'(collision), 32'd0);
        check("edge_overlap_count", 32'(collision_count), 32'd1);
        pulse_frame();
        check("next_frame_collision", 32'(collision), 32'd1);
        check("next_frame_count", 32'(collision_count), 32'd2);

        // Saturation: 260 overlap frames on top of the two already counted
        for (int f = 0; f < 260; f++) begin
            drive_pix(9'd60, 9'd61, 1'b1, 13'h00A7, 1'b1, 13'h01B5, 4'd7, 2'b01);
            pulse_frame();
            if (f == 252)
                check("count_reaches_255", 32'(collision_count), 32'd255);
        end
        check("sat_count", 32'(collision_count), 32'd255);
        check("sat_collision", 32'(collision), 32'd1);

        idle(5);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
